c_fetch_requester: RTL

//  Fetch-side initiator for the C-extension front end. Holds a halfword-aligned

---
 rtl/c_fetch_requester.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/c_fetch_requester.sv
// Fetch requester for a compressed-ISA front end: walks a halfword-aligned PC,
// reads words from the icache, and hands 16/32-bit instructions (straddles included) to decode.
module c_fetch_requester #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        req_valid_o,
    output logic [31:0] req_addr_o,
    input  logic        req_ready_i,
    input  logic        rsp_valid_i,
    input  logic [31:0] rsp_data_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        inst_compressed_o,
    input  logic        inst_ready_i
);

    typedef enum logic [2:0] {
        LOOKUP,
        REQ_LO,
        WAIT_LO,
        REQ_HI,
        WAIT_HI,
        OUT,
        DRAIN
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [29:0] buf_idx_reg;
    logic [31:0] buf_word_reg;
    logic        buf_valid_reg;

    logic        req_valid_reg;
    logic [31:0] req_addr_reg;
    logic        inst_valid_reg;
    logic [31:0] inst_reg;
    logic [31:0] pc_out_reg;
    logic        compressed_reg;

    logic        buf_hit;
    logic [15:0] buf_half;
    logic [15:0] rsp_half;
    logic        buf_compressed;
    logic        rsp_compressed;
    logic        buf_straddle;
    logic        rsp_straddle;
    logic [31:0] buf_inst;
    logic [31:0] rsp_inst;
    logic [29:0] next_idx;

    // Extraction is evaluated in parallel on the buffered word and the incoming
    // response so either source can complete an instruction in one cycle.
    assign buf_hit        = buf_valid_reg && (buf_idx_reg == pc_reg[31:2]);
    assign buf_half       = pc_reg[1] ? buf_word_reg[31:16] : buf_word_reg[15:0];
    assign rsp_half       = pc_reg[1] ? rsp_data_i[31:16] : rsp_data_i[15:0];
    assign buf_compressed = (buf_half[1:0] != 2'b11);
    assign rsp_compressed = (rsp_half[1:0] != 2'b11);
    assign buf_straddle   = pc_reg[1] && !buf_compressed;
    assign rsp_straddle   = pc_reg[1] && !rsp_compressed;
    assign buf_inst       = buf_compressed ? {16'h0000, buf_half} : buf_word_reg;
    assign rsp_inst       = rsp_compressed ? {16'h0000, rsp_half} : rsp_data_i;
    assign next_idx       = pc_reg[31:2] + 30'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= LOOKUP;
            pc_reg         <= RESET_PC & ~32'd1;
            buf_idx_reg    <= '0;
            buf_word_reg   <= '0;
            buf_valid_reg  <= 1'b0;
            req_valid_reg  <= 1'b0;
            req_addr_reg   <= '0;
            inst_valid_reg <= 1'b0;
            inst_reg       <= '0;
            pc_out_reg     <= '0;
            compressed_reg <= 1'b0;
        end else if (redirect_i) begin
            pc_reg         <= redirect_pc_i & ~32'd1;
            buf_valid_reg  <= 1'b0;
            req_valid_reg  <= 1'b0;
            inst_valid_reg <= 1'b0;
            // An accepted-but-unanswered request must have its response swallowed.
            case (state_reg)
                REQ_LO, REQ_HI:   state_reg <= req_ready_i ? DRAIN : LOOKUP;
                WAIT_LO, WAIT_HI: state_reg <= rsp_valid_i ? LOOKUP : DRAIN;
                DRAIN:            state_reg <= rsp_valid_i ? LOOKUP : DRAIN;
                default:          state_reg <= LOOKUP;
            endcase
        end else begin
            case (state_reg)
                LOOKUP: begin
                    if (buf_hit && !buf_straddle) begin
                        inst_valid_reg <= 1'b1;
                        inst_reg       <= buf_inst;
                        pc_out_reg     <= pc_reg;
                        compressed_reg <= buf_compressed;
                        state_reg      <= OUT;
                    end else if (buf_hit) begin
                        req_valid_reg <= 1'b1;
                        req_addr_reg  <= {next_idx, 2'b00};
                        state_reg     <= REQ_HI;
                    end else begin
                        req_valid_reg <= 1'b1;
                        req_addr_reg  <= {pc_reg[31:2], 2'b00};
                        state_reg     <= REQ_LO;
                    end
                end
                REQ_LO: begin
                    if (req_ready_i) begin
                        req_valid_reg <= 1'b0;
                        state_reg     <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (rsp_valid_i) begin
                        buf_idx_reg   <= pc_reg[31:2];
                        buf_word_reg  <= rsp_data_i;
                        buf_valid_reg <= 1'b1;
                        if (rsp_straddle) begin
                            req_valid_reg <= 1'b1;
                            req_addr_reg  <= {next_idx, 2'b00};
                            state_reg     <= REQ_HI;
                        end else begin
                            inst_valid_reg <= 1'b1;
                            inst_reg       <= rsp_inst;
                            pc_out_reg     <= pc_reg;
                            compressed_reg <= rsp_compressed;
                            state_reg      <= OUT;
                        end
                    end
                end
                REQ_HI: begin
                    if (req_ready_i) begin
                        req_valid_reg <= 1'b0;
                        state_reg     <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    // Upper word replaces the buffer so the trailing half is reusable.
                    if (rsp_valid_i) begin
                        inst_valid_reg <= 1'b1;
                        inst_reg       <= {rsp_data_i[15:0], buf_word_reg[31:16]};
                        pc_out_reg     <= pc_reg;
                        compressed_reg <= 1'b0;
                        buf_idx_reg    <= buf_idx_reg + 30'd1;
                        buf_word_reg   <= rsp_data_i;
                        buf_valid_reg  <= 1'b1;
                        state_reg      <= OUT;
                    end
                end
                OUT: begin
                    if (inst_ready_i) begin
                        inst_valid_reg <= 1'b0;
                        pc_reg         <= pc_reg + (compressed_reg ? 32'd2 : 32'd4);
                        state_reg      <= LOOKUP;
                    end
                end
                DRAIN: begin
                    if (rsp_valid_i) begin
                        state_reg <= LOOKUP;
                    end
                end
                default: state_reg <= LOOKUP;
            endcase
        end
    end

    assign req_valid_o       = req_valid_reg;
    assign req_addr_o        = req_addr_reg;
    assign inst_valid_o      = inst_valid_reg;
    assign inst_o            = inst_reg;
    assign pc_o              = pc_out_reg;
    assign inst_compressed_o = compressed_reg;

endmodule
